feature_acc_bank: RTL and testbench

Downstream consumer of the demux select generator. Routes each ALU result into one of sixteen signed accumulators: 4 feature-output buffers × 4 entries, addressed by buffer-use bits and per-buffer 2-bit selects. Drains all sixteen sums serially over a valid/ready port and clears the bank for the next tile. Sits between the ALU/demux-select stage and the feature-output writeback.

---
 rtl/feature_acc_bank.sv | 99 +++++++++
 tb/tb_feature_acc_bank.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/feature_acc_bank.sv
// feature_acc_bank: sixteen signed accumulators (4 buffers x 4 entries)
// with serial valid/ready drain; define ACC_SAT_EN for saturating sums.
module feature_acc_bank #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 24
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  input  logic signed [DATA_W-1:0] alu_out,
  input  logic [3:0]               buff_use,
  input  logic [7:0]               custom_demux_sel,
  input  logic                     drain_start,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic signed [ACC_W-1:0]  out_data,
  output logic [3:0]               out_addr,
  output logic                     busy,
  output logic                     drain_done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]              state;
  logic [3:0]              rd_ptr;
  logic signed [ACC_W-1:0] acc     [16];
  logic signed [ACC_W-1:0] acc_nxt [16];
  logic                    accept;

  assign accept     = (state == S_DRAIN) && out_ready;
  assign out_valid  = (state == S_DRAIN);
  assign busy       = (state != S_IDLE);
  assign drain_done = (state == S_DONE);
  assign out_addr   = rd_ptr;

  // Sign-extended add with one guard bit; clamp or wrap on overflow.
  function automatic logic signed [ACC_W-1:0] acc_add(
    input logic signed [ACC_W-1:0]  a,
    input logic signed [DATA_W-1:0] b
  );
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a}
      + {{(ACC_W+1-DATA_W){b[DATA_W-1]}}, b};
`ifdef ACC_SAT_EN
    if (s[ACC_W] != s[ACC_W-1]) begin
      if (s[ACC_W])
        return {1'b1, {(ACC_W-1){1'b0}}};
      else
        return {1'b0, {(ACC_W-1){1'b1}}};
    end
`endif
    return s[ACC_W-1:0];
  endfunction

  // Next bank contents: accumulate in IDLE, clear each entry as it drains.
  always_comb begin
    for (int k = 0; k < 16; k++) begin
      acc_nxt[k] = acc[k];
      if (state == S_IDLE && alu_valid && buff_use[k/4]
          && custom_demux_sel[2*(k/4) +: 2] == 2'(k % 4))
        acc_nxt[k] = acc_add(acc[k], alu_out);
      if (accept && rd_ptr == 4'(k))
        acc_nxt[k] = '0;
    end
  end

  // Bank, drain pointer, registered read data and control state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      rd_ptr   <= '0;
      out_data <= '0;
      for (int k = 0; k < 16; k++) acc[k] <= '0;
    end else begin
      for (int k = 0; k < 16; k++) acc[k] <= acc_nxt[k];
      unique case (state)
        S_IDLE: begin
          if (drain_start) begin
            state    <= S_DRAIN;
            rd_ptr   <= '0;
            out_data <= acc_nxt[0];
          end
        end
        S_DRAIN: begin
          if (out_ready) begin
            rd_ptr   <= rd_ptr + 4'd1;
            out_data <= acc[rd_ptr + 4'd1];
            if (rd_ptr == 4'd15) state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_feature_acc_bank.sv
// tb_feature_acc_bank: directed checks of accumulate, drain,
// stall, ignore-while-busy, overflow and mid-drain reset.
module tb_feature_acc_bank;

  logic               clk = 1'b0;
  logic               rst;
  logic               alu_valid;
  logic signed [15:0] alu_out;
  logic [3:0]         buff_use;
  logic [7:0]         sel;
  logic               drain_start;
  logic               out_ready;
  logic               out_valid;
  logic signed [23:0] out_data;
  logic [3:0]         out_addr;
  logic               busy;
  logic               drain_done;

  int total = 0;
  int bad   = 0;
  logic signed [23:0] ev [16];

  feature_acc_bank dut (
    .clk              (clk),
    .rst              (rst),
    .alu_valid        (alu_valid),
    .alu_out          (alu_out),
    .buff_use         (buff_use),
    .custom_demux_sel (sel),
    .drain_start      (drain_start),
    .out_ready        (out_ready),
    .out_valid        (out_valid),
    .out_data         (out_data),
    .out_addr         (out_addr),
    .busy             (busy),
    .drain_done       (drain_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d",
             tag, $signed(obs), $signed(exp));
    end
  endtask

  task automatic clr_ev();
    for (int k = 0; k < 16; k++) ev[k] = '0;
  endtask

  task automatic acc_n(input logic signed [15:0] v,
                       input logic [3:0] bu,
                       input logic [7:0] s,
                       input int n);
    alu_valid = 1'b1;
    alu_out   = v;
    buff_use  = bu;
    sel       = s;
    repeat (n) @(negedge clk);
    alu_valid = 1'b0;
  endtask

  // mode 0: ready=1; 1: ready toggles; 2: alu hammered; 3: rst at addr 7
  task automatic do_drain(input string tag, input int mode);
    int  idx;
    bit  done;
    idx  = 0;
    done = 1'b0;
    drain_start = 1'b1;
    @(negedge clk);
    drain_start = 1'b0;
    if (mode == 2) begin
      alu_valid = 1'b1;
      alu_out   = 16'sd100;
      buff_use  = 4'hf;
      sel       = 8'h00;
    end else begin
      alu_valid = 1'b0;
    end
    chk({tag, "_busy_start"}, 32'(busy), 1);
    for (int cyc = 1; cyc <= 40 && !done; cyc++) begin
      if (drain_done) begin
        done      = 1'b1;
        alu_valid = 1'b0;
        chk({tag, "_count"}, idx, 16);
        chk({tag, "_done_ov"}, 32'(out_valid), 0);
        if (mode != 1) chk({tag, "_done_cyc"}, cyc, 17);
        out_ready = 1'b0;
        @(negedge clk);
        chk({tag, "_idle_busy"}, 32'(busy), 0);
        chk({tag, "_idle_done"}, 32'(drain_done), 0);
      end else if (!out_valid) begin
        done = 1'b1;
        chk({tag, "_valid_drop"}, 32'(out_valid), 1);
      end else begin
        chk({tag, "_addr"}, 32'(out_addr), idx);
        chk({tag, "_data"}, out_data, ev[idx]);
        if (mode == 3 && idx == 7) begin
          done      = 1'b1;
          out_ready = 1'b0;
          rst       = 1'b1;
          @(negedge clk);
          rst = 1'b0;
          chk({tag, "_rst_ov"}, 32'(out_valid), 0);
          chk({tag, "_rst_busy"}, 32'(busy), 0);
          chk({tag, "_rst_done"}, 32'(drain_done), 0);
          @(negedge clk);
          chk({tag, "_rst_done2"}, 32'(drain_done), 0);
        end else begin
          out_ready = (mode == 1) ? cyc[0] : 1'b1;
          if (out_ready) idx++;
          @(negedge clk);
        end
      end
    end
    if (!done) chk({tag, "_timeout"}, 0, 1);
    out_ready = 1'b0;
    alu_valid = 1'b0;
  endtask

  initial begin
    rst         = 1'b1;
    alu_valid   = 1'b0;
    alu_out     = '0;
    buff_use    = '0;
    sel         = '0;
    drain_start = 1'b0;
    out_ready   = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_ov", 32'(out_valid), 0);
    chk("rst_data", out_data, 0);
    chk("rst_addr", 32'(out_addr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(drain_done), 0);

    acc_n(16'sd5, 4'b0001, 8'h03, 3);
    clr_ev();
    ev[3] = 24'sd15;
    do_drain("t1", 0);

    acc_n(-16'sd7, 4'b1111, 8'b11_10_01_00, 1);
    clr_ev();
    ev[0]  = -24'sd7;
    ev[5]  = -24'sd7;
    ev[10] = -24'sd7;
    ev[15] = -24'sd7;
    do_drain("t2_toggle", 1);
    clr_ev();
    do_drain("t2_zero", 0);

    acc_n(16'sd2, 4'b0001, 8'h00, 1);
    clr_ev();
    ev[0] = 24'sd2;
    do_drain("t3_busy_alu", 2);
    clr_ev();
    do_drain("t3_zero", 0);

    alu_valid = 1'b1;
    alu_out   = 16'sd3;
    buff_use  = 4'b0010;
    sel       = 8'h04;
    clr_ev();
    ev[5] = 24'sd3;
    do_drain("t4_same_cyc", 0);

    acc_n(16'sd32767, 4'b0001, 8'h00, 256);
    acc_n(16'sd248, 4'b0001, 8'h00, 1);
    acc_n(16'sd100, 4'b0001, 8'h00, 1);
    clr_ev();
`ifdef ACC_SAT_EN
    ev[0] = 24'sd8388607;
`else
    ev[0] = -24'sd8388516;
`endif
    do_drain("t5_ovf", 0);

    acc_n(16'sd9, 4'b1111, 8'hff, 1);
    clr_ev();
    ev[3]  = 24'sd9;
    ev[7]  = 24'sd9;
    ev[11] = 24'sd9;
    ev[15] = 24'sd9;
    do_drain("t6_rst", 3);
    clr_ev();
    do_drain("t6_zero", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
